// File: rtl/config_desc_fifo.sv
// Descriptor FIFO that feeds burst length and base address to the cached arbiter.
// It is first-word-fall-through: the head entry is always visible on the rd_* outputs.
// Pops are gated on the head's kind matching the stage the arbiter is serving.
// Sticky flags record illegal bursts and kind mismatches until w_err_clr.
//
// Handshake:
//  - Write side uses valid/ready. A push completes on a rising edge with
//    w_wr_valid & w_wr_ready. w_wr_ready depends only on registered occupancy,
//    so there is no combinational path from the read side to the write side.
//    A completed push with an illegal burst is dropped and sets w_err_burst.
//  - Read side uses w_rd_en as the request and w_rd_valid as the qualifier.
//    A pop happens when w_rd_en & w_rd_valid and w_rd_kind matches the head kind.
module config_desc_fifo #(
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int CONFIG_WIDTH        = 16,
    parameter int BURST_WIDTH         = 6,
    parameter int DEPTH               = 8
) (
    input  logic                           w_clock,
    input  logic                           w_rst_n,
    input  logic                           w_wr_valid,
    output logic                           w_wr_ready,
    input  logic [1:0]                     w_wr_kind,
    input  logic [CONFIG_WIDTH-1:0]        w_wr_burst,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_wr_addr,
    input  logic                           w_rd_en,
    input  logic [1:0]                     w_rd_kind,
    output logic                           w_rd_valid,
    output logic [1:0]                     w_rd_kind_o,
    output logic [CONFIG_WIDTH-1:0]        w_rd_burst,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_rd_addr,
    output logic [$clog2(DEPTH+1)-1:0]     w_count,
    output logic                           w_err_burst,
    output logic                           w_err_kind,
    input  logic                           w_err_clr,
    output logic [1:0]                     w_dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CONFIG_WIDTH-1:0] MAX_BURST = CONFIG_WIDTH'((1 << BURST_WIDTH) - 1);
    localparam logic [CNT_W-1:0]        FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    occ_t                           occ_state;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [CNT_W-1:0]               count;
    logic [CNT_W-1:0]               count_next;

    logic [1:0]                     kind_mem  [DEPTH];
    logic [CONFIG_WIDTH-1:0]        burst_mem [DEPTH];
    logic [MAIN_MEM_ADDR_WIDTH-1:0] addr_mem  [DEPTH];

    logic push_acc;
    logic burst_legal;
    logic push_ok;
    logic pop_req;
    logic pop_ok;
    logic kind_bad;
    logic empty;

    assign empty       = (occ_state == OCC_EMPTY);
    assign w_wr_ready  = (occ_state != OCC_FULL);
    assign w_rd_valid  = !empty;
    assign push_acc    = w_wr_valid & w_wr_ready;
    assign burst_legal = (w_wr_burst != '0) && (w_wr_burst <= MAX_BURST);
    assign push_ok     = push_acc & burst_legal;
    assign pop_req     = w_rd_en & w_rd_valid;
    assign pop_ok      = pop_req & (w_rd_kind == kind_mem[rd_ptr]);
    assign kind_bad    = pop_req & (w_rd_kind != kind_mem[rd_ptr]);

    // Head entry falls through from storage; forced to zero while nothing is held
    assign w_rd_kind_o = empty ? '0 : kind_mem[rd_ptr];
    assign w_rd_burst  = empty ? '0 : burst_mem[rd_ptr];
    assign w_rd_addr   = empty ? '0 : addr_mem[rd_ptr];
    assign w_count     = count;
    assign w_dbg_state = occ_state;

    // Next occupancy: push alone grows, pop alone shrinks, both or neither hold
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Descriptor storage; not reset, only the pointers/count define validity
    always_ff @(posedge w_clock) begin
        if (push_ok) begin
            kind_mem[wr_ptr]  <= w_wr_kind;
            burst_mem[wr_ptr] <= w_wr_burst;
            addr_mem[wr_ptr]  <= w_wr_addr;
        end
    end

    // Pointers, occupancy count and EMPTY/PARTIAL/FULL state
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            occ_state <= OCC_EMPTY;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (count_next == '0)
                occ_state <= OCC_EMPTY;
            else if (count_next == FULL_CNT)
                occ_state <= OCC_FULL;
            else
                occ_state <= OCC_PARTIAL;
        end
    end

    // Sticky error flags; a new error in the same cycle wins over a clear
    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_err_burst <= 1'b0;
            w_err_kind  <= 1'b0;
        end else begin
            if (push_acc && !burst_legal) w_err_burst <= 1'b1;
            else if (w_err_clr)           w_err_burst <= 1'b0;
            if (kind_bad)                 w_err_kind  <= 1'b1;
            else if (w_err_clr)           w_err_kind  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_config_desc_fifo.sv
// Self-checking bench for config_desc_fifo: directed scenarios followed by a
// randomized phase, all checked against a queue-based descriptor model.
module tb_config_desc_fifo;

    localparam int AW    = 32;
    localparam int CW    = 16;
    localparam int BW    = 6;
    localparam int DEPTH = 8;
    localparam int CNTW  = $clog2(DEPTH+1);
    localparam int MAXB  = (1 << BW) - 1;

    typedef struct {
        logic [1:0]    kind;
        logic [CW-1:0] burst;
        logic [AW-1:0] addr;
    } desc_t;

    logic            w_clock;
    logic            w_rst_n;
    logic            w_wr_valid;
    logic            w_wr_ready;
    logic [1:0]      w_wr_kind;
    logic [CW-1:0]   w_wr_burst;
    logic [AW-1:0]   w_wr_addr;
    logic            w_rd_en;
    logic [1:0]      w_rd_kind;
    logic            w_rd_valid;
    logic [1:0]      w_rd_kind_o;
    logic [CW-1:0]   w_rd_burst;
    logic [AW-1:0]   w_rd_addr;
    logic [CNTW-1:0] w_count;
    logic            w_err_burst;
    logic            w_err_kind;
    logic            w_err_clr;
    logic [1:0]      w_dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents plus the two sticky flags
    desc_t m_q[$];
    logic  m_err_burst;
    logic  m_err_kind;

    config_desc_fifo #(
        .MAIN_MEM_ADDR_WIDTH(AW),
        .CONFIG_WIDTH(CW),
        .BURST_WIDTH(BW),
        .DEPTH(DEPTH)
    ) dut (
        .w_clock(w_clock),
        .w_rst_n(w_rst_n),
        .w_wr_valid(w_wr_valid),
        .w_wr_ready(w_wr_ready),
        .w_wr_kind(w_wr_kind),
        .w_wr_burst(w_wr_burst),
        .w_wr_addr(w_wr_addr),
        .w_rd_en(w_rd_en),
        .w_rd_kind(w_rd_kind),
        .w_rd_valid(w_rd_valid),
        .w_rd_kind_o(w_rd_kind_o),
        .w_rd_burst(w_rd_burst),
        .w_rd_addr(w_rd_addr),
        .w_count(w_count),
        .w_err_burst(w_err_burst),
        .w_err_kind(w_err_kind),
        .w_err_clr(w_err_clr),
        .w_dbg_state(w_dbg_state)
    );

    // Clock and reset
    initial w_clock = 1'b0;
    always #5 w_clock = ~w_clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model's view of the FIFO
    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        check({tag, ".count"},    64'(w_count),     64'(sz));
        check({tag, ".rd_valid"}, 64'(w_rd_valid),  64'(sz != 0));
        check({tag, ".wr_ready"}, 64'(w_wr_ready),  64'(sz < DEPTH));
        check({tag, ".kind"},     64'(w_rd_kind_o), (sz != 0) ? 64'(m_q[0].kind)  : 64'd0);
        check({tag, ".burst"},    64'(w_rd_burst),  (sz != 0) ? 64'(m_q[0].burst) : 64'd0);
        check({tag, ".addr"},     64'(w_rd_addr),   (sz != 0) ? 64'(m_q[0].addr)  : 64'd0);
        check({tag, ".err_b"},    64'(w_err_burst), 64'(m_err_burst));
        check({tag, ".err_k"},    64'(w_err_kind),  64'(m_err_kind));
        check({tag, ".state"},    64'(w_dbg_state), (sz == 0) ? 64'd0 : (sz == DEPTH) ? 64'd2 : 64'd1);
    endtask

    // One clock: decide the model's outcome from pre-edge inputs, then check after the edge
    task automatic cycle(input string tag);
        int    sz;
        bit    push_acc, legal, do_pop, kerr;
        desc_t d;
        sz       = m_q.size();
        push_acc = w_wr_valid && (sz < DEPTH);
        legal    = (w_wr_burst >= 1) && (w_wr_burst <= MAXB);
        do_pop   = w_rd_en && (sz > 0) && (w_rd_kind == m_q[0].kind);
        kerr     = w_rd_en && (sz > 0) && (w_rd_kind != m_q[0].kind);
        d.kind   = w_wr_kind;
        d.burst  = w_wr_burst;
        d.addr   = w_wr_addr;
        @(posedge w_clock);
        #1;
        if (do_pop) void'(m_q.pop_front());
        if (push_acc && legal) m_q.push_back(d);
        if (push_acc && !legal) m_err_burst = 1'b1;
        else if (w_err_clr)     m_err_burst = 1'b0;
        if (kerr)               m_err_kind = 1'b1;
        else if (w_err_clr)     m_err_kind = 1'b0;
        check_all(tag);
    endtask

    // Driver tasks
    task automatic idle();
        w_wr_valid = 1'b0;
        w_wr_kind  = 2'd0;
        w_wr_burst = '0;
        w_wr_addr  = '0;
        w_rd_en    = 1'b0;
        w_rd_kind  = 2'd0;
        w_err_clr  = 1'b0;
    endtask

    task automatic set_push(input logic [1:0] k, input logic [CW-1:0] b, input logic [AW-1:0] a);
        w_wr_valid = 1'b1;
        w_wr_kind  = k;
        w_wr_burst = b;
        w_wr_addr  = a;
    endtask

    task automatic set_pop(input logic [1:0] k);
        w_rd_en   = 1'b1;
        w_rd_kind = k;
    endtask

    task automatic push(input string tag, input logic [1:0] k, input logic [CW-1:0] b, input logic [AW-1:0] a);
        idle();
        set_push(k, b, a);
        cycle(tag);
        idle();
    endtask

    task automatic pop(input string tag, input logic [1:0] k);
        idle();
        set_pop(k);
        cycle(tag);
        idle();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 4 * DEPTH) begin
            pop(tag, m_q[0].kind);
            guard++;
        end
        check({tag, ".drained"}, 64'(m_q.size()), 64'd0);
    endtask

    initial begin
        idle();
        m_err_burst = 1'b0;
        m_err_kind  = 1'b0;
        w_rst_n = 1'b0;
        #23;
        check_all("reset_hold");
        w_rst_n = 1'b1;
        @(posedge w_clock);
        #1;
        check_all("reset_release");

        // 1. Asynchronous reset mid-cycle discards content before the next edge
        push("t1_push", 2'd0, 16'd4, 32'h10);
        push("t1_push", 2'd1, 16'd5, 32'h20);
        push("t1_push", 2'd2, 16'd6, 32'h30);
        #3;
        w_rst_n = 1'b0;
        #1;
        m_q.delete();
        m_err_burst = 1'b0;
        m_err_kind  = 1'b0;
        check("t1_async_count", 64'(w_count), 64'd0);
        check("t1_async_valid", 64'(w_rd_valid), 64'd0);
        #2;
        w_rst_n = 1'b1;
        #1;
        check("t1_ready_after", 64'(w_wr_ready), 64'd1);
        check_all("t1_after_release");

        // 2. Fill to DEPTH, hold off one more push, then one pop reopens the write side
        for (int i = 0; i < DEPTH; i++) push("t2_fill", 2'd1, 16'd16, 32'h1000 + 32'(i));
        check("t2_full_ready", 64'(w_wr_ready), 64'd0);
        push("t2_held", 2'd1, 16'd16, 32'hDEAD);
        pop("t2_pop", 2'd1);
        check("t2_count7", 64'(w_count), 64'd7);
        drain("t2_drain");

        // 3. Illegal bursts are dropped and flagged; clear works; set beats clear
        push("t3_b0", 2'd0, 16'd0, 32'h1);
        push("t3_b64", 2'd0, 16'd64, 32'h2);
        check("t3_err", 64'(w_err_burst), 64'd1);
        idle(); w_err_clr = 1'b1; cycle("t3_clr"); idle();
        idle(); set_push(2'd0, 16'd0, 32'h3); w_err_clr = 1'b1; cycle("t3_set_vs_clr"); idle();
        push("t3_b63", 2'd3, 16'd63, 32'h4);
        push("t3_b1", 2'd3, 16'd1, 32'h5);
        idle(); w_err_clr = 1'b1; cycle("t3_clr2"); idle();
        drain("t3_drain");

        // 4. Kind ordering and mismatch handling
        push("t4_push", 2'd0, 16'd16, 32'h100);
        push("t4_push", 2'd1, 16'd16, 32'h200);
        push("t4_push", 2'd2, 16'd16, 32'h300);
        pop("t4_mismatch", 2'd1);
        check("t4_head_addr", 64'(w_rd_addr), 64'h100);
        pop("t4_pop0", 2'd0);
        pop("t4_pop1", 2'd1);
        pop("t4_pop2", 2'd2);
        pop("t4_empty_pop", 2'd3);
        idle(); w_err_clr = 1'b1; cycle("t4_clr"); idle();

        // 5. Steady occupancy of 4 with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 4; i++) push("t5_prefill", 2'(i), 16'(i + 1), 32'h500 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            idle();
            set_push(2'($urandom_range(0, 3)), 16'($urandom_range(1, MAXB)), $urandom);
            set_pop(m_q[0].kind);
            cycle("t5_stream");
        end
        idle();
        check("t5_count", 64'(w_count), 64'd4);
        drain("t5_drain");

        // 6. Push and pop together while empty: push lands, pop ignored
        idle();
        set_push(2'd2, 16'd9, 32'h600);
        set_pop(2'd2);
        cycle("t6_push_pop_empty");
        idle();
        drain("t6_drain");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 99) < 55) begin
                if ($urandom_range(0, 9) == 0)
                    set_push(2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 16'd0 : 16'($urandom_range(64, 65535)), $urandom);
                else
                    set_push(2'($urandom_range(0, 3)), 16'($urandom_range(1, MAXB)), $urandom);
            end
            if ($urandom_range(0, 99) < 50) begin
                if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                    set_pop(m_q[0].kind);
                else
                    set_pop(2'($urandom_range(0, 3)));
            end
            w_err_clr = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        idle();
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
